// File: rtl/yarvi_me_arb.sv
// yarvi_me_arb: shares the yarvi_me data port between the execute stage (A) and a secondary master (B).
// Reads carry a source bit in the memory tag so responses route back with no buffering.
module yarvi_me_arb #(
  parameter int AW = 64,
  parameter int DW = 64,
  parameter int TW = 4,
  parameter int STARVE_MAX = 4,
  parameter int MAX_OUT = 8
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          a_valid,
  output logic          a_ready,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  input  logic [1:0]    a_size,
  input  logic          a_sext,
  input  logic [TW-1:0] a_tag,
  input  logic          b_valid,
  output logic          b_ready,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  input  logic [1:0]    b_size,
  input  logic          b_sext,
  input  logic [TW-1:0] b_tag,
  output logic          a_rvalid,
  output logic          b_rvalid,
  output logic [TW-1:0] r_tag,
  output logic [DW-1:0] r_data,
  output logic          mem_valid,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [1:0]    mem_size,
  output logic          mem_sext,
  output logic [TW:0]   mem_tag,
  input  logic          me_ready,
  input  logic          me_readdatavalid,
  input  logic [TW:0]   me_readdatatag,
  input  logic [DW-1:0] me_readdata,
  output logic          err
);
  typedef enum logic {SRC_A, SRC_B} src_t;
  logic lock_q, lock_d, err_q, err_d;
  src_t owner_q, owner_d, sel;
  logic [3:0] starve_q, starve_d, out_q, out_d;
  logic elig_a, elig_b, xfer, rd_xfer, sel_b;
  always_comb begin
    elig_a = a_valid && (a_we || out_q < 4'(MAX_OUT));
    elig_b = b_valid && (b_we || out_q < 4'(MAX_OUT));
    // A locked request keeps its owner even if it would no longer be eligible
    sel = lock_q ? owner_q : (elig_b && (!elig_a || starve_q == 4'(STARVE_MAX))) ? SRC_B : SRC_A;
    sel_b = sel == SRC_B;
    mem_valid = reset_n && (lock_q || elig_a || elig_b);
    xfer = mem_valid && me_ready;
    a_ready = xfer && !sel_b;
    b_ready = xfer && sel_b;
    mem_we = sel_b ? b_we : a_we;
    mem_addr = sel_b ? b_addr : a_addr;
    mem_wdata = sel_b ? b_wdata : a_wdata;
    mem_size = sel_b ? b_size : a_size;
    mem_sext = sel_b ? b_sext : a_sext;
    mem_tag = {sel_b, sel_b ? b_tag : a_tag};
    rd_xfer = xfer && !mem_we;
    a_rvalid = reset_n && me_readdatavalid && !me_readdatatag[TW];
    b_rvalid = reset_n && me_readdatavalid && me_readdatatag[TW];
    r_tag = me_readdatatag[TW-1:0];
    r_data = me_readdata;
    err = err_q;
    lock_d = xfer ? 1'b0 : mem_valid ? 1'b1 : lock_q;
    owner_d = (mem_valid && !me_ready) ? sel : owner_q;
    starve_d = (!b_valid || b_ready) ? 4'd0 :
               (a_ready && starve_q != 4'(STARVE_MAX)) ? starve_q + 4'd1 : starve_q;
    out_d = (rd_xfer == me_readdatavalid) ? out_q : rd_xfer ? out_q + 4'd1 :
            (out_q == 4'd0) ? 4'd0 : out_q - 4'd1;
    err_d = err_q || (me_readdatavalid && out_q == 4'd0);
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      lock_q <= 1'b0;
      owner_q <= SRC_A;
      starve_q <= 4'd0;
      out_q <= 4'd0;
      err_q <= 1'b0;
    end else begin
      lock_q <= lock_d;
      owner_q <= owner_d;
      starve_q <= starve_d;
      out_q <= out_d;
      err_q <= err_d;
    end
endmodule

// File: tb/tb_yarvi_me_arb.sv
// tb_yarvi_me_arb: directed scenario tasks with hand-computed expectations for yarvi_me_arb.
module tb_yarvi_me_arb;
  localparam int AW = 64, DW = 64, TW = 4;
  logic clock = 1'b0, reset_n;
  logic a_valid, a_ready, a_we, a_sext, b_valid, b_ready, b_we, b_sext;
  logic [AW-1:0] a_addr, b_addr, mem_addr;
  logic [DW-1:0] a_wdata, b_wdata, mem_wdata, r_data, me_readdata;
  logic [1:0] a_size, b_size, mem_size;
  logic [TW-1:0] a_tag, b_tag, r_tag;
  logic a_rvalid, b_rvalid, mem_valid, mem_we, mem_sext, me_ready, me_readdatavalid, err;
  logic [TW:0] mem_tag, me_readdatatag;
  int checks = 0, errors = 0;

  yarvi_me_arb #(.AW(AW), .DW(DW), .TW(TW), .STARVE_MAX(4), .MAX_OUT(8)) dut (
    .clock(clock), .reset_n(reset_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_size(a_size), .a_sext(a_sext), .a_tag(a_tag),
    .b_valid(b_valid), .b_ready(b_ready), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_size(b_size), .b_sext(b_sext), .b_tag(b_tag),
    .a_rvalid(a_rvalid), .b_rvalid(b_rvalid), .r_tag(r_tag), .r_data(r_data),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_size(mem_size), .mem_sext(mem_sext), .mem_tag(mem_tag),
    .me_ready(me_ready), .me_readdatavalid(me_readdatavalid), .me_readdatatag(me_readdatatag),
    .me_readdata(me_readdata), .err(err)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    {a_valid, a_we, a_sext, b_valid, b_we, b_sext, me_readdatavalid} = '0;
    {a_addr, b_addr, a_wdata, b_wdata, a_size, b_size, a_tag, b_tag} = '0;
    me_readdatatag = '0;
    me_readdata = '0;
    me_ready = 1'b1;
    #12;
    a_valid = 1'b1;
    me_readdatavalid = 1'b1;
    #1;
    checks++;
    if ({mem_valid, a_ready, b_ready, a_rvalid, b_rvalid, err} !== 6'b0) begin
      $display("FAIL reset_outputs got=%b want=000000", {mem_valid, a_ready, b_ready, a_rvalid, b_rvalid, err});
      errors++;
    end
    a_valid = 1'b0;
    me_readdatavalid = 1'b0;
    me_ready = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    tick;
  endtask

  task automatic test_read_a;
    a_valid = 1'b1; a_we = 1'b0; a_addr = 64'h100; a_tag = 4'd3; me_ready = 1'b1;
    #1;
    checks++;
    if ({a_ready, b_ready, mem_valid, mem_tag} !== {3'b101, 5'h03} || mem_addr !== 64'h100) begin
      $display("FAIL read_a_issue got rdy=%b mv=%b tag=%h addr=%h want rdy=10 mv=1 tag=03 addr=100",
               {a_ready, b_ready}, mem_valid, mem_tag, mem_addr);
      errors++;
    end
    tick;
    a_valid = 1'b0; me_ready = 1'b0;
    me_readdatavalid = 1'b1; me_readdatatag = 5'h03; me_readdata = 64'hDEAD;
    #1;
    checks++;
    if ({a_rvalid, b_rvalid} !== 2'b10 || r_tag !== 4'd3 || r_data !== 64'hDEAD) begin
      $display("FAIL read_a_resp got rv=%b tag=%h data=%h want rv=10 tag=3 data=dead",
               {a_rvalid, b_rvalid}, r_tag, r_data);
      errors++;
    end
    tick;
    me_readdatavalid = 1'b0;
    #1;
    checks++;
    if (err !== 1'b0 || dut.out_q !== 4'd0) begin
      $display("FAIL read_a_drain got err=%b out=%0d want err=0 out=0", err, dut.out_q);
      errors++;
    end
  endtask

  task automatic test_starve;
    logic [9:0] exp_b;
    exp_b = 10'b10_0001_0000;
    a_valid = 1'b1; a_we = 1'b1; b_valid = 1'b1; b_we = 1'b1; me_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++;
      if ({a_ready, b_ready} !== {!exp_b[i], exp_b[i]}) begin
        $display("FAIL starve_grant_%0d got a/b=%b want a/b=%b", i, {a_ready, b_ready}, {!exp_b[i], exp_b[i]});
        errors++;
      end
      tick;
    end
    a_valid = 1'b0; b_valid = 1'b0; me_ready = 1'b0;
    tick;
  endtask

  task automatic test_stall_a;
    a_valid = 1'b1; a_we = 1'b1; a_addr = 64'h200; a_wdata = 64'h11; a_tag = 4'd1;
    b_valid = 1'b1; b_we = 1'b1; b_addr = 64'h300; b_wdata = 64'h22; b_tag = 4'd2;
    me_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (mem_valid !== 1'b1 || {a_ready, b_ready} !== 2'b00 || mem_addr !== 64'h200 ||
          mem_wdata !== 64'h11 || mem_tag !== 5'h01) begin
        $display("FAIL stall_hold_%0d got mv=%b rdy=%b addr=%h wd=%h tag=%h want mv=1 rdy=00 addr=200 wd=11 tag=01",
                 i, mem_valid, {a_ready, b_ready}, mem_addr, mem_wdata, mem_tag);
        errors++;
      end
      tick;
    end
    me_ready = 1'b1;
    #1;
    checks++;
    if ({a_ready, b_ready} !== 2'b10) begin
      $display("FAIL stall_release got a/b=%b want 10", {a_ready, b_ready});
      errors++;
    end
    tick;
    a_valid = 1'b0;
    #1;
    checks++;
    if ({a_ready, b_ready} !== 2'b01 || mem_tag !== 5'h12 || mem_addr !== 64'h300) begin
      $display("FAIL stall_then_b got a/b=%b tag=%h addr=%h want a/b=01 tag=12 addr=300",
               {a_ready, b_ready}, mem_tag, mem_addr);
      errors++;
    end
    tick;
    b_valid = 1'b0; me_ready = 1'b0;
    tick;
  endtask

  task automatic test_lock_b;
    b_valid = 1'b1; b_we = 1'b1; b_addr = 64'h500; b_tag = 4'd5; me_ready = 1'b0;
    tick;
    a_valid = 1'b1; a_we = 1'b1; a_addr = 64'h600;
    #1;
    checks++;
    if (mem_tag !== 5'h15 || mem_addr !== 64'h500 || {a_ready, b_ready} !== 2'b00) begin
      $display("FAIL lock_b_hold got tag=%h addr=%h a/b=%b want tag=15 addr=500 a/b=00",
               mem_tag, mem_addr, {a_ready, b_ready});
      errors++;
    end
    me_ready = 1'b1;
    #1;
    checks++;
    if ({a_ready, b_ready} !== 2'b01) begin
      $display("FAIL lock_b_release got a/b=%b want 01", {a_ready, b_ready});
      errors++;
    end
    tick;
    b_valid = 1'b0;
    #1;
    checks++;
    if ({a_ready, b_ready} !== 2'b10 || mem_addr !== 64'h600) begin
      $display("FAIL lock_b_then_a got a/b=%b addr=%h want a/b=10 addr=600", {a_ready, b_ready}, mem_addr);
      errors++;
    end
    tick;
    a_valid = 1'b0; me_ready = 1'b0;
    tick;
  endtask

  task automatic test_max_out;
    a_valid = 1'b1; a_we = 1'b0; me_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a_tag = 4'(i);
      #1;
      checks++;
      if (a_ready !== 1'b1) begin
        $display("FAIL max_out_issue_%0d got a_ready=%b want 1", i, a_ready);
        errors++;
      end
      tick;
    end
    a_tag = 4'd8;
    #1;
    checks++;
    if ({mem_valid, a_ready} !== 2'b00) begin
      $display("FAIL max_out_block got mv/a_ready=%b want 00", {mem_valid, a_ready});
      errors++;
    end
    b_valid = 1'b1; b_we = 1'b1; b_addr = 64'h400;
    #1;
    checks++;
    if ({b_ready, a_ready, mem_we} !== 3'b101) begin
      $display("FAIL max_out_b_write got b/a/we=%b want 101", {b_ready, a_ready, mem_we});
      errors++;
    end
    tick;
    b_valid = 1'b0;
    me_readdatavalid = 1'b1; me_readdatatag = 5'h00;
    #1;
    checks++;
    if (mem_valid !== 1'b0) begin
      $display("FAIL max_out_resp_cycle got mem_valid=%b want 0", mem_valid);
      errors++;
    end
    tick;
    me_readdatavalid = 1'b0;
    #1;
    checks++;
    if (a_ready !== 1'b1) begin
      $display("FAIL max_out_regrant got a_ready=%b want 1", a_ready);
      errors++;
    end
    tick;
    a_valid = 1'b0; me_ready = 1'b0; me_readdatavalid = 1'b1;
    for (int i = 0; i < 8; i++) tick;
    me_readdatavalid = 1'b0;
    #1;
    checks++;
    if (dut.out_q !== 4'd0 || err !== 1'b0) begin
      $display("FAIL max_out_drain got out=%0d err=%b want out=0 err=0", dut.out_q, err);
      errors++;
    end
  endtask

  task automatic test_same_cycle;
    a_valid = 1'b1; a_we = 1'b0; me_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick;
    me_readdatavalid = 1'b1; me_readdatatag = 5'h00;
    #1;
    checks++;
    if (dut.out_q !== 4'd5 || a_ready !== 1'b1) begin
      $display("FAIL same_cycle_pre got out=%0d a_ready=%b want out=5 a_ready=1", dut.out_q, a_ready);
      errors++;
    end
    tick;
    a_valid = 1'b0; me_ready = 1'b0;
    #1;
    checks++;
    if (dut.out_q !== 4'd5) begin
      $display("FAIL same_cycle_post got out=%0d want 5", dut.out_q);
      errors++;
    end
    for (int i = 0; i < 5; i++) tick;
    me_readdatavalid = 1'b0;
    #1;
    checks++;
    if (dut.out_q !== 4'd0 || err !== 1'b0) begin
      $display("FAIL same_cycle_drain got out=%0d err=%b want out=0 err=0", dut.out_q, err);
      errors++;
    end
  endtask

  task automatic test_err_reset;
    me_readdatavalid = 1'b1; me_readdatatag = 5'h17; me_readdata = 64'hBEEF;
    #1;
    checks++;
    if ({a_rvalid, b_rvalid} !== 2'b01 || r_tag !== 4'd7) begin
      $display("FAIL err_route got rv=%b tag=%h want rv=01 tag=7", {a_rvalid, b_rvalid}, r_tag);
      errors++;
    end
    tick;
    me_readdatavalid = 1'b0;
    tick;
    checks++;
    if (err !== 1'b1 || dut.out_q !== 4'd0) begin
      $display("FAIL err_sticky got err=%b out=%0d want err=1 out=0", err, dut.out_q);
      errors++;
    end
    a_valid = 1'b1; a_we = 1'b1; a_addr = 64'h700; me_ready = 1'b0;
    tick;
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({mem_valid, a_ready, err, dut.lock_q} !== 4'b0000) begin
      $display("FAIL err_async_reset got mv/ar/err/lock=%b want 0000", {mem_valid, a_ready, err, dut.lock_q});
      errors++;
    end
    a_valid = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    tick;
  endtask

  initial begin
    test_reset;
    test_read_a;
    test_starve;
    test_stall_a;
    test_lock_b;
    test_max_out;
    test_same_cycle;
    test_err_reset;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/yarvi_me_arb.md
Name: yarvi_me_arb

Overview:
Two-requester arbiter that shares the single yarvi_me data-memory port between the execute stage (port A, primary) and a secondary master (port B: refill/debug/DMA).
- Sits between the requesters and yarvi_me.
- Tracks outstanding reads.
- Prevents port B starvation.
- Steers read responses back to their source by extending the read tag with a source bit.

Parameters:
AW, 64, address width (matches `VMSB+1)
DW, 64, data width (matches `XMSB+1)
TW, 4, requester read-tag width; the memory-side tag is TW+1 bits
STARVE_MAX, 4, consecutive A grants while B waits before B is forced in; legal range 1..15
MAX_OUT, 8, maximum outstanding reads, total across both ports; legal range 1..15

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
a_valid, b_valid  in  1  request present
a_ready, b_ready  out  1  request accepted this cycle
a_we, b_we  in  1  write enable (0 = read)
a_addr, b_addr  in  AW  address
a_wdata, b_wdata  in  DW  write data
a_size, b_size  in  2  sizelg2
a_sext, b_sext  in  1  read sign-extend
a_tag, b_tag  in  TW  read tag
a_rvalid, b_rvalid  out  1  read data returned to this port
r_tag  out  TW  returned tag, low TW bits of me_readdatatag
r_data  out  DW  returned data, broadcast to both ports
mem_valid  out  1  to yarvi_me valid
mem_we, mem_addr, mem_wdata, mem_size, mem_sext  out  1/AW/DW/2/1  muxed payload
mem_tag  out  TW+1  {src, tag}; src 0 = A, 1 = B
me_ready  in  1  memory accepts a request
me_readdatavalid  in  1  read response valid
me_readdatatag  in  TW+1  response tag
me_readdata  in  DW  response data
err  out  1  sticky: response arrived with zero reads outstanding

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- State registers: lock, owner, starve_cnt[3:0], out_cnt[3:0], err.
- Reset values: lock=0, owner=A, starve_cnt=0, out_cnt=0, err=0.
- While reset_n=0, all valid/ready outputs (mem_valid, a_ready, b_ready, a_rvalid, b_rvalid) are forced 0.
- Transfer = mem_valid && me_ready, evaluated on the same cycle.
- Requester rule: valid and payload stay stable until ready. Ready is combinational: ready = (sel==port) && me_ready && mem_valid.
- Eligibility: a request is eligible if it is a write, or if out_cnt < MAX_OUT. An ineligible read is not granted and not driven.
- Selection (combinational), when lock=0:
  - Only one port eligible: that port.
  - Both eligible: B if starve_cnt==STARVE_MAX, else A.
  - Neither eligible: mem_valid=0.
- Selection when lock=1: sel=owner. The request was already driven and eligibility is not re-checked; the payload is driven unchanged.
- Lock update:
  - mem_valid && !me_ready: lock<=1, owner<=sel.
  - On transfer: lock<=0.
  - A presented request is never withdrawn or swapped.
- starve_cnt update:
  - A transfer while b_valid=1: increment, saturating at STARVE_MAX.
  - B transfer, or b_valid=0: cleared to 0.
- out_cnt update:
  - +1 on a read transfer; -1 on me_readdatavalid.
  - Both in the same cycle: unchanged.
  - Never exceeds MAX_OUT.
  - Response while out_cnt==0: out_cnt stays 0 and err<=1. err clears only on reset.
- Response routing:
  - a_rvalid = me_readdatavalid && !me_readdatatag[TW].
  - b_rvalid = me_readdatavalid && me_readdatatag[TW].
  - Zero added latency; no response buffering, so requesters must always accept.
- Payload mux: mem_* taken from sel; mem_tag = {sel==B, sel_tag}.
- Reset asserted mid-operation: lock, counters and err clear immediately. Outstanding responses arriving after reset release are routed by tag but set err, because out_cnt=0.

Test Plan:
- A read addr 0x100 tag 3, me_ready=1 → a_ready=1 same cycle, mem_tag=0x03. Response tag 0x03, data 0xDEAD → a_rvalid=1, r_tag=3, r_data=0xDEAD.
- a_valid and b_valid held high, me_ready=1, STARVE_MAX=4, all writes → grant order A,A,A,A,B,A,A,A,A,B.
- A request with me_ready=0 for 3 cycles while B also requests → mem_* stable on A's payload, b_ready=0. On the cycle me_ready rises, a_ready=1. Next cycle B wins only if eligible and STARVE rules allow.
- Issue 8 reads with no responses (MAX_OUT=8) → 9th read is not driven (mem_valid=0); a write from B is still granted. One response returns → the read is granted the following cycle.
- Read transfer and response in the same cycle at out_cnt=5 → out_cnt stays 5.
- Response with out_cnt=0 → err=1 and stays set; pulse reset_n low mid-lock → lock=0, mem_valid=0 asynchronously, err=0.
